// File: rtl/fb_pkg.sv
// fb_pkg: constants and types shared by the write-side fill engine and the
// read-side scan transformer of the downscaled frame buffer.
//   HSIZE/VSIZE : buffer geometry in buffer pixels
//   AWIDTH      : buffer address width
//   DWIDTH      : pixel width (RGB444)
//   CWIDTH      : signed request coordinate width
//   SWIDTH      : unsigned rectangle width/height width
package fb_pkg;

  localparam int HSIZE  = 160;
  localparam int VSIZE  = 120;
  localparam int AWIDTH = 15;
  localparam int DWIDTH = 12;
  localparam int CWIDTH = 10;
  localparam int SWIDTH = 8;

  typedef logic [DWIDTH-1:0] color_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fill_state_t;

  // Walk coordinates carry one extra bit so x0+w / y0+h never wrap.
  localparam logic signed [CWIDTH:0] COORD_ONE = {{CWIDTH{1'b0}}, 1'b1};
  localparam logic [SWIDTH-1:0]      CNT_ONE   = {{(SWIDTH-1){1'b0}}, 1'b1};
  localparam logic [SWIDTH-1:0]      CNT_ZERO  = {SWIDTH{1'b0}};

  // Sign-extend a request coordinate into the walk coordinate width.
  function automatic logic signed [CWIDTH:0] sext_coord(input logic signed [CWIDTH-1:0] c);
    return {c[CWIDTH-1], c};
  endfunction

endpackage

// File: rtl/xy_to_addr.sv
// xy_to_addr: combinational map of a signed buffer coordinate to its
// row-major buffer address (y*HSIZE + x, truncated) and a range flag.
//   x, y     : signed coordinates, CWIDTH+1 bits
//   addr     : buffer address, only meaningful when in_range=1
//   in_range : 0<=x<HSIZE and 0<=y<VSIZE
module xy_to_addr
  import fb_pkg::*;
(
  input  logic signed [CWIDTH:0] x,
  input  logic signed [CWIDTH:0] y,
  output logic [AWIDTH-1:0]      addr,
  output logic                   in_range
);

  // Wide enough that the signed product and sum never overflow.
  localparam int PW = CWIDTH + AWIDTH + 2;
  localparam logic signed [PW-1:0]   HS_W   = PW'(HSIZE);
  localparam logic signed [CWIDTH:0] C_ZERO = {(CWIDTH+1){1'b0}};
  localparam logic signed [CWIDTH:0] C_HMAX = (CWIDTH+1)'(HSIZE);
  localparam logic signed [CWIDTH:0] C_VMAX = (CWIDTH+1)'(VSIZE);

  logic signed [PW-1:0] xs;
  logic signed [PW-1:0] ys;
  logic signed [PW-1:0] lin;

  // Linear address and clip test.
  always_comb begin
    xs       = {{(PW-CWIDTH-1){x[CWIDTH]}}, x};
    ys       = {{(PW-CWIDTH-1){y[CWIDTH]}}, y};
    lin      = ys * HS_W + xs;
    addr     = lin[AWIDTH-1:0];
    in_range = (x >= C_ZERO) && (x < C_HMAX) && (y >= C_ZERO) && (y < C_VMAX);
  end

endmodule

// File: rtl/rect_fill_writer.sv
// rect_fill_writer: accepts one rectangle-fill request per handshake and
// writes the rectangle in raster order, one buffer pixel per cycle, clipping
// pixels that fall outside the buffer (clipped pixels still take a cycle).
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/ready   : request handshake (ready only while idle)
//   req_x, req_y      : signed top-left corner
//   req_w, req_h      : rectangle size; zero area completes with no writes
//   req_color         : fill value
//   wr_en/addr/data   : buffer write port (registered)
//   busy              : high while pixels are being walked
//   done              : one-cycle completion pulse
module rect_fill_writer
  import fb_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic signed [CWIDTH-1:0] req_x,
  input  logic signed [CWIDTH-1:0] req_y,
  input  logic [SWIDTH-1:0]        req_w,
  input  logic [SWIDTH-1:0]        req_h,
  input  logic [DWIDTH-1:0]        req_color,
  output logic                     wr_en,
  output logic [AWIDTH-1:0]        wr_addr,
  output logic [DWIDTH-1:0]        wr_data,
  output logic                     busy,
  output logic                     done
);

  fill_state_t             state;
  logic signed [CWIDTH:0]  x0;
  logic signed [CWIDTH:0]  cx;
  logic signed [CWIDTH:0]  cy;
  logic [SWIDTH-1:0]       w_m1;
  // Remaining columns after the current one / rows after the current row.
  logic [SWIDTH-1:0]       col_left;
  logic [SWIDTH-1:0]       row_left;

  logic signed [CWIDTH:0]  nx;
  logic signed [CWIDTH:0]  ny;
  logic                    last_pixel;
  logic [AWIDTH-1:0]       n_addr;
  logic                    n_in_range;

  // Coordinate of the pixel to be presented in the next cycle.
  always_comb begin
    nx         = cx;
    ny         = cy;
    last_pixel = (col_left == CNT_ZERO) && (row_left == CNT_ZERO);
    if (state == IDLE) begin
      nx = sext_coord(req_x);
      ny = sext_coord(req_y);
    end else if (col_left != CNT_ZERO) begin
      nx = cx + COORD_ONE;
    end else begin
      nx = x0;
      ny = cy + COORD_ONE;
    end
  end

  xy_to_addr u_xy_to_addr (
    .x        (nx),
    .y        (ny),
    .addr     (n_addr),
    .in_range (n_in_range)
  );

  // Fill FSM with registered handshake and write-port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= {AWIDTH{1'b0}};
      wr_data   <= {DWIDTH{1'b0}};
      x0        <= {(CWIDTH+1){1'b0}};
      cx        <= {(CWIDTH+1){1'b0}};
      cy        <= {(CWIDTH+1){1'b0}};
      w_m1      <= CNT_ZERO;
      col_left  <= CNT_ZERO;
      row_left  <= CNT_ZERO;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b0;
          wr_en     <= 1'b0;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            x0        <= nx;
            wr_data   <= req_color;
            if ((req_w == CNT_ZERO) || (req_h == CNT_ZERO)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= RUN;
              busy     <= 1'b1;
              cx       <= nx;
              cy       <= ny;
              w_m1     <= req_w - CNT_ONE;
              col_left <= req_w - CNT_ONE;
              row_left <= req_h - CNT_ONE;
              wr_en    <= n_in_range;
              wr_addr  <= n_addr;
            end
          end
        end
        RUN: begin
          req_ready <= 1'b0;
          if (last_pixel) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            wr_en <= 1'b0;
          end else begin
            busy    <= 1'b1;
            done    <= 1'b0;
            cx      <= nx;
            cy      <= ny;
            wr_en   <= n_in_range;
            wr_addr <= n_addr;
            if (col_left != CNT_ZERO) begin
              col_left <= col_left - CNT_ONE;
            end else begin
              col_left <= w_m1;
              row_left <= row_left - CNT_ONE;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b0;
          wr_en     <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b0;
          wr_en     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rect_fill_writer.md
Name: rect_fill_writer

Overview:
- Write side of the downscaled sprite/frame buffer; the scan-side address transformer reads this buffer.
- Accepts one rectangle-fill request per handshake, walks the rectangle in raster order and issues one buffer write per cycle.
- Uses the same row-major mapping as the read side: addr = y*HSIZE + x.
- Clips pixels outside the buffer. Used for clearing, backgrounds and solid obstacles.

Parameters:
- HSIZE, 160, buffer width in buffer pixels (640/4)
- VSIZE, 120, buffer height in buffer pixels (480/4)
- AWIDTH, 15, buffer address width
- CWIDTH, 10, signed request coordinate width
- SWIDTH, 8, unsigned rectangle width/height field width
- DWIDTH, 12, pixel data width (RGB444)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block idle, request will be accepted
- req_x  in  CWIDTH signed  left column
- req_y  in  CWIDTH signed  top row
- req_w  in  SWIDTH  width in pixels
- req_h  in  SWIDTH  height in pixels
- req_color  in  DWIDTH  fill value
- wr_en  out  1  buffer write strobe
- wr_addr  out  AWIDTH  buffer write address
- wr_data  out  DWIDTH  buffer write data
- busy  out  1  fill in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- One clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset values: req_ready=1, busy=0, done=0, wr_en=0, wr_addr=0, wr_data=0. All outputs are registered.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - req_ready=1.
  - Acceptance cycle A is the cycle whose closing edge samples req_valid&req_ready.
  - At that edge, the block latches x0, y0, w, h and color.
  - If w==0 or h==0, go to DONE with no writes.
  - Otherwise go to RUN and register pixel 0 at (x0,y0).
- RUN:
  - req_ready=0, busy=1.
  - Pixel k is on the write port during cycle A+1+k, with exactly one pixel per cycle and no stalls.
  - Raster order: x increments first; when x reaches x0+w-1, x returns to x0 and y increments.
  - After pixel w*h-1 the block goes to DONE.
- DONE:
  - Lasts one cycle. done=1, busy=0, wr_en=0, req_ready=0.
  - Returns to IDLE.
  - done appears in cycle A+1+w*h; for zero area it appears in cycle A+1.
- Clipping:
  - A pixel is written (wr_en=1) only if 0<=x<HSIZE and 0<=y<VSIZE, evaluated in signed CWIDTH+1 arithmetic.
  - A clipped pixel still consumes its cycle with wr_en=0, so total latency is independent of clipping.
- Address and data:
  - wr_addr = y*HSIZE + x, truncated to AWIDTH; it is only meaningful when wr_en=1.
  - wr_data = latched color throughout the request.
- Request handling:
  - req_* inputs are ignored outside IDLE.
  - Requests are never queued; a request held high during RUN or DONE is accepted on the first IDLE cycle.
- Coordinates: use signed arithmetic throughout. With x0+w crossing CWIDTH range the walk must still terminate after exactly w columns; the counters count remaining columns and rows, not end coordinates.
- rst asserted mid-RUN:
  - At the next edge, return to IDLE with reset values.
  - No done pulse and no further writes.

Decomposition:
- Package fb_pkg:
  - HSIZE, VSIZE, AWIDTH and DWIDTH constants shared with the read-side transformer.
  - color_t typedef (logic [DWIDTH-1:0]).
  - fill_state_t enum {IDLE, RUN, DONE}.
- One sub-module xy_to_addr: combinational signed (x,y) to {addr, in_range}. It is the write-side dual of the read transformer and is reused by future blitters.

Test Plan:
- Basic fill: x=2, y=3, w=2, h=2, color 0xF00 accepted in cycle A -> writes at addr 482, 483, 642, 643 in cycles A+1..A+4 with data 0xF00; done in A+5; req_ready high in A+6.
- Left clip: x=-1, y=0, w=3, h=1 -> wr_en pattern 0,1,1 at addr -,0,1; done in A+4.
- Corner clip: x=159, y=119, w=2, h=2 -> single write at addr 19199 in A+1; A+2..A+4 have wr_en=0; done in A+5.
- Zero area: w=0, h=5 -> no wr_en, done in A+1, busy never high.
- Busy ignore: second request asserted during RUN of a 4x1 fill -> not accepted until IDLE; second fill starts exactly one cycle after the first done.
- Mid-op reset: rst in cycle A+2 of a 4x4 fill -> from the next cycle wr_en=0, done never pulses, req_ready=1; a new request then completes normally.
